// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD text refresh block.
package lcd_pkg;

   // Top-level sequencing states
   typedef enum logic [3:0] {
      StIdle,
      StCmdL1,
      StCmdL2,
      StFetch,
      StLatch,
      StTx,
      StGap,
      StNextChar,
      StFin
   } lcd_state_e;

   // Nibble transmitter states
   typedef enum logic [2:0] {
      TxIdle,
      TxSetup,
      TxHigh,
      TxNib,
      TxHold
   } lcd_tx_state_e;

   localparam logic [7:0] LCD_CMD_LINE1 = 8'h80;
   localparam logic [7:0] LCD_CMD_LINE2 = 8'hC0;

   localparam int unsigned LCD_CHARS_PER_LINE = 16;
   localparam int unsigned LCD_CHARS_TOTAL    = 32;

   // Down-counter reload value; a requested duration of 0 still lasts 1 cycle
   function automatic logic [15:0] timer_load(input int unsigned cycles);
      return (cycles == 0) ? 16'd0 : 16'(cycles - 1);
   endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Sends one byte to an HD44780 4-bit bus as two strobed nibbles, upper first.
// Owns setup, enable-high and inter-nibble timing.
module lcd_nibble_tx import lcd_pkg::*; #(
   parameter int unsigned T_SETUP  = 2,
   parameter int unsigned T_E_HIGH = 12,
   parameter int unsigned T_NIB    = 50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_byte,
   input  logic       rs,
   input  logic       go,
   output logic [3:0] lcd_data,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       ready
);

   lcd_tx_state_e state_q, state_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [7:0]    byte_q, byte_d;
   logic [3:0]    nib_q, nib_d;
   logic          rs_q, rs_d;
   logic          e_q, e_d;
   logic          low_q, low_d;

   // Strobe sequencer: setup -> E high -> (gap, lower nibble) or final hold
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      byte_d  = byte_q;
      nib_d   = nib_q;
      rs_d    = rs_q;
      e_d     = e_q;
      low_d   = low_q;
      unique case (state_q)
         TxIdle: begin
            if (go) begin
               byte_d  = tx_byte;
               nib_d   = tx_byte[7:4];
               rs_d    = rs;
               low_d   = 1'b0;
               cnt_d   = timer_load(T_SETUP);
               state_d = TxSetup;
            end
         end
         TxSetup: begin
            if (cnt_q == 16'd0) begin
               e_d     = 1'b1;
               cnt_d   = timer_load(T_E_HIGH);
               state_d = TxHigh;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         TxHigh: begin
            if (cnt_q == 16'd0) begin
               e_d = 1'b0;
               if (low_q) begin
                  state_d = TxHold;
               end else begin
                  cnt_d   = timer_load(T_NIB);
                  state_d = TxNib;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         TxNib: begin
            // Upper nibble stays on the bus through the gap, covering the hold cycle
            if (cnt_q == 16'd0) begin
               nib_d   = byte_q[3:0];
               low_d   = 1'b1;
               cnt_d   = timer_load(T_SETUP);
               state_d = TxSetup;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         TxHold: begin
            state_d = TxIdle;
         end
         default: begin
            state_d = TxIdle;
         end
      endcase
   end

   // State and bus registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= TxIdle;
         cnt_q   <= 16'd0;
         byte_q  <= 8'd0;
         nib_q   <= 4'd0;
         rs_q    <= 1'b0;
         e_q     <= 1'b0;
         low_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         byte_q  <= byte_d;
         nib_q   <= nib_d;
         rs_q    <= rs_d;
         e_q     <= e_d;
         low_q   <= low_d;
      end
   end

   assign lcd_data = nib_q;
   assign lcd_e    = e_q;
   assign lcd_rs   = rs_q;
   assign ready    = (state_q == TxIdle);

endmodule

// File: rtl/lcd_text_refresh.sv
// Copies 32 characters from the character BRAM to a 2x16 LCD per start pulse.
// Define LCD_TEXT_REFRESH_LOOP_EN for continuous refresh after the first start.
module lcd_text_refresh import lcd_pkg::*; #(
   parameter logic [10:0] BASE_ADDR = 11'h000,
   parameter int unsigned T_SETUP   = 2,
   parameter int unsigned T_E_HIGH  = 12,
   parameter int unsigned T_NIB     = 50,
   parameter int unsigned T_CHAR    = 2000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [10:0] bram_addr,
   input  logic [7:0]  bram_do,
   output logic [3:0]  lcd_data,
   output logic        lcd_e,
   output logic        lcd_rs,
   output logic        lcd_rw,
   output logic        busy,
   output logic        done
);

   lcd_state_e  state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic [15:0] gap_q, gap_d;
   logic [10:0] addr_q, addr_d;
   logic [7:0]  byte_q, byte_d;
   logic        rs_q, rs_d;
   logic        go_q, go_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        tx_ready;

   // Pass sequencing: commands, BRAM fetch, byte transmit and inter-char gap
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      addr_d  = addr_q;
      byte_d  = byte_q;
      rs_d    = rs_q;
      go_d    = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               busy_d  = 1'b1;
               idx_d   = 5'd0;
               state_d = StCmdL1;
            end
         end
         StCmdL1: begin
            byte_d  = LCD_CMD_LINE1;
            rs_d    = 1'b0;
            go_d    = 1'b1;
            state_d = StTx;
         end
         StCmdL2: begin
            byte_d  = LCD_CMD_LINE2;
            rs_d    = 1'b0;
            go_d    = 1'b1;
            state_d = StTx;
         end
         StFetch: begin
            state_d = StLatch;
         end
         StLatch: begin
            byte_d  = bram_do;
            rs_d    = 1'b1;
            go_d    = 1'b1;
            state_d = StTx;
         end
         StTx: begin
            // go_q masks the ready still showing in the cycle the byte is handed over
            if (!go_q && tx_ready) begin
               gap_d   = timer_load(T_CHAR);
               state_d = StGap;
            end
         end
         StGap: begin
            if (gap_q != 16'd0) begin
               gap_d = gap_q - 16'd1;
            end else if (!rs_q) begin
               state_d = StFetch;
            end else if (idx_q == 5'(LCD_CHARS_PER_LINE - 1)) begin
               idx_d   = 5'(LCD_CHARS_PER_LINE);
               state_d = StCmdL2;
            end else if (idx_q == 5'(LCD_CHARS_TOTAL - 1)) begin
               state_d = StFin;
            end else begin
               state_d = StNextChar;
            end
         end
         StNextChar: begin
            idx_d   = idx_q + 5'd1;
            state_d = StFetch;
         end
         StFin: begin
`ifdef LCD_TEXT_REFRESH_LOOP_EN
            idx_d   = 5'd0;
            state_d = StCmdL1;
`else
            state_d = StIdle;
`endif
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      if (state_d == StFin) begin
         done_d = 1'b1;
`ifndef LCD_TEXT_REFRESH_LOOP_EN
         busy_d = 1'b0;
`endif
      end
      // Address is registered so it is on the bus for the whole FETCH cycle
      if (state_d == StFetch) begin
         addr_d = BASE_ADDR + 11'(idx_d);
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         idx_q   <= 5'd0;
         gap_q   <= 16'd0;
         addr_q  <= BASE_ADDR;
         byte_q  <= 8'd0;
         rs_q    <= 1'b0;
         go_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         addr_q  <= addr_d;
         byte_q  <= byte_d;
         rs_q    <= rs_d;
         go_q    <= go_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   lcd_nibble_tx #(
      .T_SETUP  (T_SETUP),
      .T_E_HIGH (T_E_HIGH),
      .T_NIB    (T_NIB)
   ) u_tx (
      .clk      (clk),
      .reset    (reset),
      .tx_byte  (byte_q),
      .rs       (rs_q),
      .go       (go_q),
      .lcd_data (lcd_data),
      .lcd_e    (lcd_e),
      .lcd_rs   (lcd_rs),
      .ready    (tx_ready)
   );

   assign bram_addr = addr_q;
   assign lcd_rw    = 1'b0;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_lcd_text_refresh.sv
// Bench for lcd_text_refresh: two instances (base 0x000 and 0x7F0) share one BRAM image.
module tb_lcd_text_refresh;

   localparam int unsigned TS = 2;
   localparam int unsigned TE = 3;
   localparam int unsigned TN = 4;
   localparam int unsigned TC = 5;
   localparam logic [10:0] BASE0 = 11'h000;
   localparam logic [10:0] BASE1 = 11'h7F0;

   logic        clk = 1'b0;
   logic        rst [2];
   logic        st [2];
   logic [10:0] m_addr [2];
   logic [7:0]  bdo [2];
   logic [3:0]  m_data [2];
   logic        m_e [2];
   logic        m_rs [2];
   logic        m_rw [2];
   logic        m_busy [2];
   logic        m_done [2];

   logic [7:0]  mem [2048];

   int total = 0;
   int bad   = 0;

   // reference model state
   logic        active [2];
   logic [8:0]  exp_bytes [2][34];
   int          exp_ptr [2];
   int          pass_str [2];
   int          hi_cnt [2];
   int          done_cnt [2];
   int          passes [2];
   int          skip [2];
   logic        prev_e [2];
   logic        half [2];
   logic [4:0]  up [2];
   logic [4:0]  s_nib [2];
   logic [4:0]  h1 [2];
   logic [4:0]  h2 [2];
   logic [10:0] prev_addr [2];
   logic [4:0]  cur;
   logic [8:0]  e_tmp;
   logic [10:0] a_tmp;
   logic [10:0] b_tmp;

   always #10 clk = ~clk;

   lcd_text_refresh #(
      .BASE_ADDR (BASE0), .T_SETUP (TS), .T_E_HIGH (TE), .T_NIB (TN), .T_CHAR (TC)
   ) dut0 (
      .clk (clk), .reset (rst[0]), .start (st[0]), .bram_addr (m_addr[0]),
      .bram_do (bdo[0]), .lcd_data (m_data[0]), .lcd_e (m_e[0]), .lcd_rs (m_rs[0]),
      .lcd_rw (m_rw[0]), .busy (m_busy[0]), .done (m_done[0])
   );

   lcd_text_refresh #(
      .BASE_ADDR (BASE1), .T_SETUP (TS), .T_E_HIGH (TE), .T_NIB (TN), .T_CHAR (TC)
   ) dut1 (
      .clk (clk), .reset (rst[1]), .start (st[1]), .bram_addr (m_addr[1]),
      .bram_do (bdo[1]), .lcd_data (m_data[1]), .lcd_e (m_e[1]), .lcd_rs (m_rs[1]),
      .lcd_rw (m_rw[1]), .busy (m_busy[1]), .done (m_done[1])
   );

   // synchronous-read BRAM, one read port per instance
   always @(posedge clk) begin
      bdo[0] <= mem[m_addr[0]];
      bdo[1] <= mem[m_addr[1]];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // monitor + reference model, sampled on the falling edge
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         b_tmp = (k == 0) ? BASE0 : BASE1;
         cur = {m_rs[k], m_data[k]};
         if (m_done[k] === 1'b1) begin
            done_cnt[k]++;
            check("pass_strobes", pass_str[k], 68);
            check("pass_bytes", exp_ptr[k], 34);
            active[k] = 1'b0;
         end
         check("busy", m_busy[k], active[k]);
         // address must step through base+0..31 (mod 2048), one new value per fetch
         if (skip[k] == 0 && m_addr[k] !== prev_addr[k]) begin
            a_tmp = b_tmp + 11'(((prev_addr[k] - b_tmp) + 11'd1) & 11'h01F);
            check("addr_step", m_addr[k], a_tmp);
         end
         prev_addr[k] = m_addr[k];
         if (m_e[k] && !prev_e[k]) begin
            check("setup_stable", {h2[k], h1[k]}, {cur, cur});
            check("rw", m_rw[k], 0);
            s_nib[k] = cur;
            hi_cnt[k] = 1;
            pass_str[k]++;
            if (!half[k]) begin
               up[k] = cur;
               half[k] = 1'b1;
            end else begin
               half[k] = 1'b0;
               if (exp_ptr[k] < 34) begin
                  e_tmp = exp_bytes[k][exp_ptr[k]];
                  check("byte", {up[k][4], cur[4], up[k][3:0], cur[3:0]},
                        {e_tmp[8], e_tmp[8], e_tmp[7:0]});
                  exp_ptr[k]++;
               end else begin
                  check("extra_byte", 1, 0);
               end
            end
         end else if (m_e[k]) begin
            check("e_high_stable", cur, s_nib[k]);
            hi_cnt[k]++;
         end else if (prev_e[k]) begin
            check("e_width", hi_cnt[k], TE);
            check("hold_after_fall", cur, s_nib[k]);
         end
         prev_e[k] = m_e[k];
         h2[k] = h1[k];
         h1[k] = cur;
         if (rst[k]) begin
            active[k]   = 1'b0;
            half[k]     = 1'b0;
            prev_e[k]   = 1'b0;
            exp_ptr[k]  = 34;
            pass_str[k] = 0;
            skip[k]     = 1;
         end else begin
            if (skip[k] > 0) skip[k]--;
            if (st[k] && !active[k]) begin
               active[k]   = 1'b1;
               exp_ptr[k]  = 0;
               pass_str[k] = 0;
               half[k]     = 1'b0;
               exp_bytes[k][0]  = 9'h080;
               exp_bytes[k][17] = 9'h0C0;
               for (int i = 0; i < 32; i++) begin
                  a_tmp = b_tmp + 11'(i);
                  exp_bytes[k][(i < 16) ? i + 1 : i + 2] = {1'b1, mem[a_tmp]};
               end
            end
         end
      end
   end

   task automatic run_pass(input logic [1:0] mask);
      int n;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         st[k] = mask[k];
         if (mask[k]) passes[k]++;
      end
      @(posedge clk); #1;
      st[0] = 1'b0;
      st[1] = 1'b0;
      n = 0;
      while ((m_busy[0] || m_busy[1]) && n < 6000) begin
         // stray starts while busy must be ignored
         for (int k = 0; k < 2; k++)
            if (m_busy[k] && $urandom_range(0, 99) == 0) st[k] = 1'b1;
         @(posedge clk); #1;
         st[0] = 1'b0;
         st[1] = 1'b0;
         n++;
      end
      if (n >= 6000) check("pass_timeout", 1, 0);
      repeat (2 + $urandom_range(0, 5)) @(posedge clk);
   endtask

   task automatic fill_mem(input bit ramp);
      for (int i = 0; i < 2048; i++)
         mem[i] = (ramp && i < 32) ? 8'(i) : 8'($urandom);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; st[k] = 1'b0; active[k] = 1'b0; exp_ptr[k] = 34;
         pass_str[k] = 0; hi_cnt[k] = 0; done_cnt[k] = 0; passes[k] = 0; skip[k] = 1;
         prev_e[k] = 1'b0; half[k] = 1'b0; h1[k] = '0; h2[k] = '0;
         up[k] = '0; s_nib[k] = '0; prev_addr[k] = '0;
      end
      fill_mem(1'b1);
      repeat (3) @(posedge clk); #1;
      check("rst_addr0", m_addr[0], BASE0);
      check("rst_addr1", m_addr[1], BASE1);
      for (int k = 0; k < 2; k++) begin
         check("rst_data", m_data[k], 0);
         check("rst_e", m_e[k], 0);
         check("rst_rs", m_rs[k], 0);
         check("rst_rw", m_rw[k], 0);
         check("rst_busy", m_busy[k], 0);
         check("rst_done", m_done[k], 0);
      end
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      repeat (2) @(posedge clk);

      // ramp image: base 0 sends 00..1F, base 7F0 wraps into 000..00F
      run_pass(2'b11);
      for (int p = 0; p < 3; p++) begin
         fill_mem(1'b0);
         repeat ($urandom_range(1, 20)) @(posedge clk);
         run_pass(2'($urandom_range(1, 3)));
      end

      // reset during E-high of the 10th byte (19th strobe = its upper nibble)
      fill_mem(1'b0);
      @(posedge clk); #1;
      st[0] = 1'b1;
      @(posedge clk); #1;
      st[0] = 1'b0;
      begin
         int n;
         n = 0;
         while (!(pass_str[0] == 19 && m_e[0]) && n < 3000) begin
            @(posedge clk); #1;
            n++;
         end
         if (n >= 3000) check("reset_wait_timeout", 1, 0);
      end
      rst[0] = 1'b1;
      @(posedge clk); #1;
      check("midrst_e", m_e[0], 0);
      check("midrst_data", m_data[0], 0);
      check("midrst_rs", m_rs[0], 0);
      check("midrst_addr", m_addr[0], BASE0);
      check("midrst_busy", m_busy[0], 0);
      check("midrst_done", m_done[0], 0);
      rst[0] = 1'b0;
      repeat (3) @(posedge clk);
      run_pass(2'b01);

      check("done_count0", done_cnt[0], passes[0]);
      check("done_count1", done_cnt[1], passes[1]);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
